mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported-per-direction `Memory` block between the instruction-fetch unit and the load/store unit. It accepts at most one transaction per cycle, drives the memory's read/write ports from registers, returns read data with a fixed two-cycle latency, and blocks out-of-range accesses with an error response. Data-port requests have priority, and a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : fetch/load-store arbiter for a shared memory, 2-cycle read
// Revision 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned MEM_SIZE     = 1 << 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen
);

  localparam logic [31:0] C_MEM_SIZE     = 32'(MEM_SIZE);
  localparam logic [7:0]  C_STARVE_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  r_starve;
  logic        r_s1_valid;
  logic        r_s1_port;
  logic        r_s1_err;
  logic        r_i_rvalid;
  logic        r_d_rvalid;
  logic        r_i_err;
  logic        r_d_err;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_mem_raddr;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_wen;

  logic        w_starved;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_acc;
  logic [31:0] w_addr;
  logic        w_oor;
  logic        w_store;
  logic        w_rd;
  logic        w_wr;
  logic        w_rsp;

  // Fetch overrides the data port only once it has been denied long enough.
  assign w_starved = (r_starve == C_STARVE_LIMIT);
  assign w_i_gnt   = rst_n & i_req & (~d_req | w_starved);
  assign w_d_gnt   = rst_n & d_req & ~w_i_gnt;
  assign w_acc     = w_i_gnt | w_d_gnt;
  assign w_addr    = w_i_gnt ? i_addr : d_addr;
  assign w_oor     = (w_addr >= C_MEM_SIZE);
  assign w_store   = w_d_gnt & d_we;
  assign w_rd      = w_acc & ~w_store & ~w_oor;
  assign w_wr      = w_store & ~w_oor;
  assign w_rsp     = w_acc & (~w_store | w_oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve    <= 8'd0;
      r_s1_valid  <= 1'b0;
      r_s1_port   <= 1'b0;
      r_s1_err    <= 1'b0;
      r_i_rvalid  <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_mem_raddr <= 32'd0;
      r_mem_waddr <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wen   <= 1'b0;
    end else begin
      if (w_i_gnt) begin
        r_starve <= 8'd0;
      end else if (i_req && !w_starved) begin
        r_starve <= r_starve + 8'd1;
      end

      r_mem_wen <= w_wr;
      if (w_wr) begin
        r_mem_waddr <= d_addr;
        r_mem_wdata <= d_wdata;
      end
      if (w_rd) begin
        r_mem_raddr <= w_addr;
      end

      // Stage 1: port id 1 = data port; in-range stores never enter.
      r_s1_valid <= w_rsp;
      r_s1_port  <= w_d_gnt;
      r_s1_err   <= w_oor;

      r_i_rvalid <= r_s1_valid & ~r_s1_port;
      r_d_rvalid <= r_s1_valid & r_s1_port;
      r_i_err    <= r_s1_valid & ~r_s1_port & r_s1_err;
      r_d_err    <= r_s1_valid & r_s1_port & r_s1_err;
      if (r_s1_valid && !r_s1_port) begin
        r_i_rdata <= r_s1_err ? 32'd0 : mem_rdata;
      end
      if (r_s1_valid && r_s1_port) begin
        r_d_rdata <= r_s1_err ? 32'd0 : mem_rdata;
      end
    end
  end

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_raddr = r_mem_raddr;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wen   = r_mem_wen;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench with a negedge memory model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wen;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] C_W0 = 32'h1111_0000;
  localparam logic [31:0] C_W1 = 32'h2222_0001;
  localparam logic [31:0] C_W2 = 32'h3333_0002;
  localparam logic [31:0] C_W3 = 32'h4444_0003;

  logic [31:0] mem [0:63] = '{0: C_W0, 1: C_W1, 2: C_W2, 3: C_W3,
                              5: 32'hDEAD_BEEF, default: 32'h0};

  mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_wen  (mem_wen)
  );

  always #5 clk = ~clk;

  // Memory writes first, then reads, both on the falling edge.
  always @(negedge clk) begin
    if (mem_wen) mem[mem_waddr[5:0]] = mem_wdata;
    mem_rdata <= mem[mem_raddr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with a fetch request held during reset.
    i_req = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_mem_waddr", mem_waddr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single fetch from address 5.
    i_req = 1'b1; i_addr = 32'd5;
    #1;
    chk("f5_i_gnt", 32'(i_gnt), 32'd1);
    chk("f5_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    i_req = 1'b0;
    chk("f5_mem_raddr", mem_raddr, 32'd5);
    chk("f5_early_rvalid", 32'(i_rvalid), 32'd0);
    tick();
    chk("f5_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("f5_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("f5_i_err", 32'(i_err), 32'd0);
    chk("f5_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    chk("f5_rvalid_pulse", 32'(i_rvalid), 32'd0);

    // Store to 7 followed immediately by a load from 7.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0000_1234;
    #1;
    chk("st7_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    chk("st7_mem_wen", 32'(mem_wen), 32'd1);
    chk("st7_mem_waddr", mem_waddr, 32'd7);
    chk("st7_mem_wdata", mem_wdata, 32'h0000_1234);
    d_we = 1'b0;
    tick();
    d_req = 1'b0;
    chk("st7_wen_one_cycle", 32'(mem_wen), 32'd0);
    chk("st7_no_response", 32'(d_rvalid), 32'd0);
    chk("ld7_mem_raddr", mem_raddr, 32'd7);
    tick();
    chk("ld7_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("ld7_d_rdata", d_rdata, 32'h0000_1234);
    chk("ld7_i_rvalid", 32'(i_rvalid), 32'd0);

    // Contention: expect d,d,d,d,i repeating.
    i_req = 1'b1; i_addr = 32'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve_i_gnt_%0d", k), 32'(i_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_d_gnt_%0d", k), 32'(d_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("starve_last_raddr", mem_raddr, 32'd0);
    tick(); tick(); tick();

    // Out-of-range store at exactly MEM_SIZE.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0001_0000; d_wdata = 32'hFFFF_FFFF;
    #1;
    chk("oor_st_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    chk("oor_st_mem_wen", 32'(mem_wen), 32'd0);
    chk("oor_st_raddr_hold", mem_raddr, 32'd0);
    tick();
    chk("oor_st_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("oor_st_d_err", 32'(d_err), 32'd1);
    chk("oor_st_d_rdata", d_rdata, 32'd0);
    chk("oor_st_mem_wen2", 32'(mem_wen), 32'd0);

    // Out-of-range fetch.
    i_req = 1'b1; i_addr = 32'hFFFF_FFFF;
    #1;
    chk("oor_f_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    i_req = 1'b0;
    tick();
    chk("oor_f_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("oor_f_i_err", 32'(i_err), 32'd1);
    chk("oor_f_i_rdata", i_rdata, 32'd0);
    chk("oor_f_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();

    // Four back-to-back fetches from 0..3.
    i_req = 1'b1; i_addr = 32'd0;
    tick();
    i_addr = 32'd1;
    tick();
    chk("b2b_v0", 32'(i_rvalid), 32'd1);
    chk("b2b_d0", i_rdata, C_W0);
    i_addr = 32'd2;
    tick();
    chk("b2b_v1", 32'(i_rvalid), 32'd1);
    chk("b2b_d1", i_rdata, C_W1);
    i_addr = 32'd3;
    tick();
    chk("b2b_v2", 32'(i_rvalid), 32'd1);
    chk("b2b_d2", i_rdata, C_W2);
    i_req = 1'b0;
    tick();
    chk("b2b_v3", 32'(i_rvalid), 32'd1);
    chk("b2b_d3", i_rdata, C_W3);
    chk("b2b_err", 32'(i_err), 32'd0);
    tick();
    chk("b2b_end", 32'(i_rvalid), 32'd0);

    // Reset asserted while a load is in flight.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5;
    tick();
    d_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("mid_rst_mem_raddr", mem_raddr, 32'd0);
    chk("mid_rst_mem_waddr", mem_waddr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_i_rdata", i_rdata, 32'd0);
    d_req = 1'b1;
    #1;
    chk("mid_rst_d_gnt", 32'(d_gnt), 32'd0);
    d_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_d_rvalid_a", 32'(d_rvalid), 32'd0);
    tick();
    chk("post_rst_d_rvalid_b", 32'(d_rvalid), 32'd0);
    chk("post_rst_i_rvalid", 32'(i_rvalid), 32'd0);

    i_req = 1'b1; i_addr = 32'd5;
    #1;
    chk("post_rst_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    i_req = 1'b0;
    tick();
    chk("post_rst_f_rvalid", 32'(i_rvalid), 32'd1);
    chk("post_rst_f_rdata", i_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
